// File: rtl/draw_store_if.sv
// Bundle of the draw-store write/offer, status and read-port signals.
// The producer/reader side uses master; draw_store uses slave.
interface draw_store_if;
   logic       clear;
   logic       num_valid;
   logic [7:0] num_in;
   logic       accept;
   logic       rej_range;
   logic       rej_dup;
   logic       rej_full;
   logic [5:0] drawn_cnt;
   logic [5:0] level;
   logic       full;
   logic       empty;
   logic       done;
   logic       rd_req;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_last;
   logic       rd_err;

   modport master (
      output clear, num_valid, num_in, rd_req,
      input  accept, rej_range, rej_dup, rej_full, drawn_cnt, level,
             full, empty, done, rd_data, rd_valid, rd_last, rd_err
   );

   modport slave (
      input  clear, num_valid, num_in, rd_req,
      output accept, rej_range, rej_dup, rej_full, drawn_cnt, level,
             full, empty, done, rd_data, rd_valid, rd_last, rd_err
   );
endinterface

// File: rtl/draw_store.sv
// Draw result store: admits in-range, unique values into a per-game memory,
// reports every offer, and replays stored draws in order over a read port.
module draw_store #(
   parameter int unsigned DEPTH   = 20,
   parameter int unsigned MAX_NUM = 80
) (
   input logic         clk,
   input logic         rst_n,
   draw_store_if.slave bus
);
   localparam int unsigned BW      = (MAX_NUM > 2) ? $clog2(MAX_NUM) : 1;
   localparam int unsigned MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0]  MAX_V   = 8'(MAX_NUM);
   localparam logic [5:0]  DEPTH_V = 6'(DEPTH);
   localparam logic [5:0]  LAST_V  = 6'(DEPTH - 1);

   logic [7:0]          mem_q [DEPTH];
   logic [(2**BW)-1:0]  bitmap_q, bitmap_d;
   logic [5:0]          wr_ptr_q, wr_ptr_d;
   logic [5:0]          rd_ptr_q, rd_ptr_d;
   logic                accept_q, accept_d;
   logic                rej_range_q, rej_range_d;
   logic                rej_dup_q, rej_dup_d;
   logic                rej_full_q, rej_full_d;
   logic [7:0]          rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rd_last_q, rd_last_d;
   logic                rd_err_q, rd_err_d;

   logic                full, empty, in_range, is_dup, do_write;

   assign full     = (wr_ptr_q == DEPTH_V);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   // Range is judged on all 8 bits first, so only legal values index the bitmap.
   assign in_range = (bus.num_in != 8'd0) && (bus.num_in < MAX_V);
   assign is_dup   = in_range && bitmap_q[bus.num_in[BW-1:0]];

   always_comb begin
      bitmap_d    = bitmap_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_data_d   = rd_data_q;
      accept_d    = 1'b0;
      rej_range_d = 1'b0;
      rej_dup_d   = 1'b0;
      rej_full_d  = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      rd_err_d    = 1'b0;
      do_write    = 1'b0;
      if (bus.clear) begin
         bitmap_d = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (bus.num_valid) begin
            if (!in_range) begin
               rej_range_d = 1'b1;
            end else if (is_dup) begin
               rej_dup_d = 1'b1;
            end else if (full) begin
               rej_full_d = 1'b1;
            end else begin
               accept_d                        = 1'b1;
               do_write                        = 1'b1;
               bitmap_d[bus.num_in[BW-1:0]]    = 1'b1;
               wr_ptr_d                        = wr_ptr_q + 6'd1;
            end
         end
         // Read sees the pre-write occupancy, so a write into an empty store cannot be read back in the same cycle.
         if (bus.rd_req) begin
            if (empty) begin
               rd_err_d = 1'b1;
            end else begin
               rd_valid_d = 1'b1;
               rd_data_d  = mem_q[rd_ptr_q[MW-1:0]];
               rd_last_d  = (rd_ptr_q == LAST_V);
               rd_ptr_d   = rd_ptr_q + 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitmap_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_data_q   <= '0;
         accept_q    <= 1'b0;
         rej_range_q <= 1'b0;
         rej_dup_q   <= 1'b0;
         rej_full_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_err_q    <= 1'b0;
      end else begin
         bitmap_q    <= bitmap_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_data_q   <= rd_data_d;
         accept_q    <= accept_d;
         rej_range_q <= rej_range_d;
         rej_dup_q   <= rej_dup_d;
         rej_full_q  <= rej_full_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         rd_err_q    <= rd_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem_q[wr_ptr_q[MW-1:0]] <= bus.num_in;
      end
   end

   assign bus.accept    = accept_q;
   assign bus.rej_range = rej_range_q;
   assign bus.rej_dup   = rej_dup_q;
   assign bus.rej_full  = rej_full_q;
   assign bus.drawn_cnt = wr_ptr_q;
   assign bus.level     = wr_ptr_q - rd_ptr_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.done      = full && empty;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_last   = rd_last_q;
   assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_draw_store.sv
// Scoreboard bench for draw_store: a list-based game model queues expected
// offer/read responses; a negedge monitor pops and compares them.
module tb_draw_store;
   localparam int unsigned DEPTH   = 20;
   localparam int unsigned MAX_NUM = 80;

   typedef struct {
      bit         err;
      logic [7:0] data;
      bit         last;
   } rd_exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   draw_store_if bus();

   draw_store #(.DEPTH(DEPTH), .MAX_NUM(MAX_NUM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int      checks   = 0;
   int      failures = 0;
   logic [3:0] wq[$];   // {accept, rej_range, rej_dup, rej_full}
   rd_exp_t    rq[$];

   int drawn[$];
   bit seen[256];
   int rd_idx;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      drawn.delete();
      foreach (seen[i]) seen[i] = 1'b0;
      rd_idx = 0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.accept || bus.rej_range || bus.rej_dup || bus.rej_full) begin
            if (wq.size() == 0) begin
               chk("spurious_offer_pulse", 1, 0);
            end else begin
               logic [3:0] e;
               e = wq.pop_front();
               chk("offer_result", int'({bus.accept, bus.rej_range, bus.rej_dup, bus.rej_full}), int'(e));
            end
         end
         if (bus.rd_valid || bus.rd_err) begin
            if (rq.size() == 0) begin
               chk("spurious_read_pulse", 1, 0);
            end else begin
               rd_exp_t r;
               r = rq.pop_front();
               chk("rd_err", int'(bus.rd_err), int'(r.err));
               chk("rd_valid", int'(bus.rd_valid), int'(!r.err));
               if (!r.err) begin
                  chk("rd_data", int'(bus.rd_data), int'(r.data));
                  chk("rd_last", int'(bus.rd_last), int'(r.last));
               end
            end
         end
      end
   end

   task automatic check_state();
      bit f, e;
      f = (drawn.size() == DEPTH);
      e = (rd_idx == drawn.size());
      chk("drawn_cnt", int'(bus.drawn_cnt), drawn.size());
      chk("level", int'(bus.level), drawn.size() - rd_idx);
      chk("full", int'(bus.full), int'(f));
      chk("empty", int'(bus.empty), int'(e));
      chk("done", int'(bus.done), int'(f && e));
   endtask

   task automatic check_reset_values();
      chk("rst_accept", int'(bus.accept), 0);
      chk("rst_rej", int'({bus.rej_range, bus.rej_dup, bus.rej_full}), 0);
      chk("rst_drawn_cnt", int'(bus.drawn_cnt), 0);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_empty", int'(bus.empty), 1);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      chk("rst_rd_flags", int'({bus.rd_valid, bus.rd_last, bus.rd_err}), 0);
   endtask

   // Called at negedge+1; drives one cycle of stimulus and predicts its response.
   task automatic step(input bit nv, input logic [7:0] v, input bit rr, input bit clr);
      int val;
      bus.num_valid = nv;
      bus.num_in    = v;
      bus.rd_req    = rr;
      bus.clear     = clr;
      val = int'(v);
      if (clr) begin
         model_reset();
      end else begin
         if (rr) begin
            rd_exp_t r;
            if (rd_idx >= drawn.size()) begin
               r = '{err: 1'b1, data: 8'd0, last: 1'b0};
            end else begin
               r = '{err: 1'b0, data: 8'(drawn[rd_idx]), last: (rd_idx == DEPTH - 1)};
               rd_idx++;
            end
            rq.push_back(r);
         end
         if (nv) begin
            if (val == 0 || val >= MAX_NUM)      wq.push_back(4'b0100);
            else if (seen[val])                  wq.push_back(4'b0010);
            else if (drawn.size() == DEPTH)      wq.push_back(4'b0001);
            else begin
               wq.push_back(4'b1000);
               drawn.push_back(val);
               seen[val] = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      check_state();
      @(negedge clk); #1;
      chk("responses_drained", wq.size() + rq.size(), 0);
   endtask

   initial begin
      bus.clear     = 1'b0;
      bus.num_valid = 1'b0;
      bus.num_in    = 8'd0;
      bus.rd_req    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_values();
      @(negedge clk); #1;
      rst_n = 1'b1;

      step(1, 8'd20, 0, 0);
      step(1, 8'd40, 0, 0);
      step(1, 8'd5, 0, 0);
      step(1, 8'd40, 0, 0);
      step(1, 8'd0, 0, 0);
      step(1, 8'd80, 0, 0);
      step(1, 8'd200, 0, 0);

      step(0, 8'd0, 0, 1);
      for (int i = 1; i <= 21; i++) step(1, 8'(i), 0, 0);
      for (int i = 0; i < 22; i++) step(0, 8'd0, 1, 0);

      step(0, 8'd0, 0, 1);
      step(1, 8'd1, 0, 0);
      step(1, 8'd2, 0, 0);
      step(1, 8'd3, 1, 0);
      step(1, 8'd7, 0, 0);
      step(1, 8'd7, 0, 1);
      step(1, 8'd7, 0, 0);

      step(0, 8'd0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 8'(10 + i), 0, 0);
      step(0, 8'd0, 0, 0);
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      @(posedge clk); #3;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk); #1;
      step(0, 8'd0, 0, 0);
      step(0, 8'd0, 1, 0);
      step(1, 8'd10, 0, 0);

      for (int i = 0; i < 600; i++) begin
         logic [7:0] v;
         bit nv, rr, clr;
         if ($urandom_range(0, 9) == 0) v = 8'($urandom_range(128, 255));
         else                           v = 8'($urandom_range(0, MAX_NUM));
         nv  = ($urandom_range(0, 9) < 7);
         rr  = ($urandom_range(0, 9) < 4);
         clr = ($urandom_range(0, 49) == 0);
         step(nv, v, rr, clr);
      end

      step(0, 8'd0, 0, 0);
      chk("final_queues_empty", wq.size() + rq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
